logic_pod_uart_arbiter: RTL

Shares the single pod-control UART transmitter among several command sources (boot-time config ROM sequencer, host command bridge, trigger-threshold updater). It arbitrates round-robin at message granularity: a message is a byte stream terminated by LF (0x0A), and a granted source keeps the UART until its LF has been transmitted. It sits between the requesters and the UART `tx_en`/`tx_data`/`tx_done` port, and is gated by hotswap pod power.

---
 rtl/logic_pod_uart_arbiter_pkg.sv | 20 ++
 rtl/logic_pod_uart_arbiter_picker.sv | 34 +++
 rtl/logic_pod_uart_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/logic_pod_uart_arbiter_pkg.sv
// Shared types and constants for the logic-pod UART arbiter: FSM state encoding,
// the end-of-message byte and the default stall limit.
package logic_pod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  localparam logic [7:0] LOGIC_POD_EOL = 8'h0A;

  // 10 ms at 125 MHz
  localparam int unsigned LOGIC_POD_TIMEOUT_DEFAULT = 32'd1250000;

  function automatic logic is_eol(input logic [7:0] b);
    return (b == LOGIC_POD_EOL);
  endfunction

endpackage

// File: rtl/logic_pod_uart_arbiter_picker.sv
// Combinational round-robin search: first set bit of req_i found by walking
// upward from start_i and wrapping modulo NUM_REQ.
module rr_priority_picker #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IDX_W-1:0]   pick_idx_o,
  output logic               found_o
);

  logic [31:0] idx_s;

  // Rotate-search; the first hit after start_i wins.
  always_comb begin
    pick_o     = '0;
    pick_idx_o = '0;
    found_o    = 1'b0;
    idx_s      = 32'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = (32'(start_i) + 32'(k)) % 32'(NUM_REQ);
      if (!found_o && req_i[idx_s]) begin
        found_o       = 1'b1;
        pick_o[idx_s] = 1'b1;
        pick_idx_o    = idx_s[IDX_W-1:0];
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/logic_pod_uart_arbiter.sv
// Message-granular round-robin arbiter sharing one pod-control UART transmitter.
// Optional stall timeout is enabled by defining LOGIC_POD_ARB_TIMEOUT_EN.
module logic_pod_uart_arbiter
  import logic_pod_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = LOGIC_POD_TIMEOUT_DEFAULT
) (
  input  logic                 clk_125mhz,
  input  logic                 rst_n,
  input  logic                 pod_power_en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 uart_tx_en,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_done,
  output logic                 timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic               eol_q, eol_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_en_q, tx_en_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               timeout_err_q, timeout_err_d;

  logic [IDX_W-1:0]   start_s;
  logic [NUM_REQ-1:0] pick_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_found_s;
  logic               owner_valid_s;
  logic [7:0]         owner_byte_s;
  logic               cnt_expired_s;

  assign start_s       = (last_owner_q == LAST_IDX) ? IDX_W'(0) : (last_owner_q + IDX_W'(1));
  assign owner_valid_s = req_valid[owner_q];
  assign owner_byte_s  = req_data[8*owner_q +: 8];

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i      (req_valid),
    .start_i    (start_s),
    .pick_o     (pick_s),
    .pick_idx_o (pick_idx_s),
    .found_o    (pick_found_s)
  );

`ifdef LOGIC_POD_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_expired_s = (cnt_q == CNT_LAST);

  // Stall counter: restarts on any state change, runs while the owner stalls.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == ST_SEND) || (state_q == ST_WAIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign cnt_expired_s = 1'b0;
`endif

  // Arbitration FSM next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    eol_d         = eol_q;
    tx_data_d     = tx_data_q;
    tx_en_d       = 1'b0;
    req_ready_d   = '0;
    timeout_err_d = 1'b0;

    if (!pod_power_en) begin
      // In-flight byte is abandoned; the rotation pointer is kept.
      state_d = ST_IDLE;
      grant_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_found_s) begin
            grant_d = pick_s;
            owner_d = pick_idx_s;
            state_d = ST_SEND;
          end else begin
            grant_d = '0;
          end
        end
        ST_SEND: begin
          if (owner_valid_s) begin
            req_ready_d[owner_q] = 1'b1;
            tx_en_d              = 1'b1;
            tx_data_d            = owner_byte_s;
            eol_d                = is_eol(owner_byte_s);
            state_d              = ST_WAIT;
          end else if (cnt_expired_s) begin
            timeout_err_d = 1'b1;
            grant_d       = '0;
            last_owner_d  = owner_q;
            state_d       = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end
        ST_WAIT: begin
          if (uart_tx_done) begin
            if (eol_q) begin
              grant_d      = '0;
              last_owner_d = owner_q;
              state_d      = ST_IDLE;
            end else begin
              state_d = ST_SEND;
            end
          end else if (cnt_expired_s) begin
            timeout_err_d = 1'b1;
            grant_d       = '0;
            last_owner_d  = owner_q;
            state_d       = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
        default: begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      endcase
    end
  end

  // State and output registers; the pointer resets so requester 0 wins first.
  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      last_owner_q  <= LAST_IDX;
      eol_q         <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_en_q       <= 1'b0;
      req_ready_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      eol_q         <= eol_d;
      tx_data_q     <= tx_data_d;
      tx_en_q       <= tx_en_d;
      req_ready_q   <= req_ready_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant        = grant_q;
  assign busy         = |grant_q;
  assign req_ready    = req_ready_q;
  assign uart_tx_en   = tx_en_q;
  assign uart_tx_data = tx_data_q;
  assign timeout_err  = timeout_err_q;

endmodule
